// File: rtl/decode_stage.sv
// Decode stage: splits the IF/ID instruction into fields, reads the 8x16 register file
// with writeback bypass, detects load-use hazards and drives the ID/EX register.
module decode_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_IFID,
    input  logic [15:0] PC2_IFID,
    input  logic        halt_IFID,
    input  logic        takeBranch_EXMEM,
    input  logic        freeze,
    input  logic        wb_wrEn,
    input  logic [2:0]  wb_wrReg,
    input  logic [15:0] wb_wrData,
    output logic        stallCtrl,
    output logic [15:0] instr_IDEX,
    output logic [15:0] PC2_IDEX,
    output logic [15:0] rsData_IDEX,
    output logic [15:0] rtData_IDEX,
    output logic [2:0]  wrReg_IDEX,
    output logic        wrEn_IDEX,
    output logic        memRead_IDEX,
    output logic        memWrite_IDEX,
    output logic        halt_IDEX,
    output logic        err_IDEX,
    output logic [15:0] stallCnt
);

    logic [4:0]  op;
    logic [2:0]  rs, rt, rdR;
    logic [2:0]  wrRegDec;
    logic        wrEnDec, usesRs, usesRt;
    logic [15:0] rsRead, rtRead;
    logic [15:0] rf_q [8];

    logic [15:0] instr_d, instr_q, pc2_d, pc2_q, rsData_d, rsData_q, rtData_d, rtData_q;
    logic [2:0]  wrReg_d, wrReg_q;
    logic        wrEn_d, wrEn_q, memRead_d, memRead_q, memWrite_d, memWrite_q;
    logic        halt_d, halt_q, err_d, err_q;
    logic [15:0] stallCnt_d, stallCnt_q;

    assign op  = instr_IFID[15:11];
    assign rs  = instr_IFID[10:8];
    assign rt  = instr_IFID[7:5];
    assign rdR = instr_IFID[4:2];

    always_comb begin
        wrEnDec  = 1'b0;
        wrRegDec = 3'd0;
        casez (op)
            5'b11001, 5'b11010, 5'b11011, 5'b111??: begin wrEnDec = 1'b1; wrRegDec = rdR; end
            5'b010??, 5'b101??, 5'b10001:           begin wrEnDec = 1'b1; wrRegDec = rt;  end
            5'b11000, 5'b10010, 5'b10011:           begin wrEnDec = 1'b1; wrRegDec = rs;  end
            5'b0011?:                               begin wrEnDec = 1'b1; wrRegDec = 3'd7; end
            default: ;
        endcase
    end

    assign usesRs = !(op == 5'b00000 || op == 5'b00001 || op == 5'b00100 ||
                      op == 5'b00110 || op == 5'b11000);
    assign usesRt = (op == 5'b11001) || (op == 5'b11010) || (op == 5'b11011) ||
                    (op[4:2] == 3'b111) || (op == 5'b10000) || (op == 5'b10011);

    // Writeback in the same cycle is forwarded so the freshly written value is seen.
    assign rsRead = (wb_wrEn && wb_wrReg == rs) ? wb_wrData : rf_q[rs];
    assign rtRead = (wb_wrEn && wb_wrReg == rt) ? wb_wrData : rf_q[rt];

    assign stallCtrl = memRead_q & wrEn_q & ~takeBranch_EXMEM &
                       ((usesRs & (rs == wrReg_q)) | (usesRt & (rt == wrReg_q)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else if (wb_wrEn) begin
            rf_q[wb_wrReg] <= wb_wrData;
        end
    end

    always_comb begin
        instr_d    = instr_q;
        pc2_d      = pc2_q;
        rsData_d   = rsData_q;
        rtData_d   = rtData_q;
        wrReg_d    = wrReg_q;
        wrEn_d     = wrEn_q;
        memRead_d  = memRead_q;
        memWrite_d = memWrite_q;
        halt_d     = halt_q;
        err_d      = err_q;
        stallCnt_d = stallCnt_q;
        if (freeze) begin
            if (takeBranch_EXMEM || stallCtrl) begin
                instr_d    = NOP_INSTR;
                pc2_d      = '0;
                rsData_d   = '0;
                rtData_d   = '0;
                wrReg_d    = '0;
                wrEn_d     = 1'b0;
                memRead_d  = 1'b0;
                memWrite_d = 1'b0;
                halt_d     = 1'b0;
                err_d      = 1'b0;
            end else begin
                instr_d    = instr_IFID;
                pc2_d      = PC2_IFID;
                rsData_d   = rsRead;
                rtData_d   = rtRead;
                wrReg_d    = wrRegDec;
                wrEn_d     = wrEnDec;
                memRead_d  = (op == 5'b10001);
                memWrite_d = (op == 5'b10000) || (op == 5'b10011);
                halt_d     = halt_IFID;
                err_d      = (op == 5'b00010) || (op == 5'b00011);
            end
            if (stallCtrl && stallCnt_q != 16'hFFFF) stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc2_q      <= '0;
            rsData_q   <= '0;
            rtData_q   <= '0;
            wrReg_q    <= '0;
            wrEn_q     <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            instr_q    <= instr_d;
            pc2_q      <= pc2_d;
            rsData_q   <= rsData_d;
            rtData_q   <= rtData_d;
            wrReg_q    <= wrReg_d;
            wrEn_q     <= wrEn_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign instr_IDEX    = instr_q;
    assign PC2_IDEX      = pc2_q;
    assign rsData_IDEX   = rsData_q;
    assign rtData_IDEX   = rtData_q;
    assign wrReg_IDEX    = wrReg_q;
    assign wrEn_IDEX     = wrEn_q;
    assign memRead_IDEX  = memRead_q;
    assign memWrite_IDEX = memWrite_q;
    assign halt_IDEX     = halt_q;
    assign err_IDEX      = err_q;
    assign stallCnt      = stallCnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, bypass, load-use stall, flush priority,
// freeze hold, stall-counter saturation and destination/flag decode.
module tb_decode_stage;

    logic        clk, rst;
    logic [15:0] instr_IFID, PC2_IFID, wb_wrData;
    logic        halt_IFID, takeBranch_EXMEM, freeze, wb_wrEn;
    logic [2:0]  wb_wrReg;
    logic        stallCtrl;
    logic [15:0] instr_IDEX, PC2_IDEX, rsData_IDEX, rtData_IDEX, stallCnt;
    logic [2:0]  wrReg_IDEX;
    logic        wrEn_IDEX, memRead_IDEX, memWrite_IDEX, halt_IDEX, err_IDEX;

    int checks = 0;
    int failures = 0;

    logic [15:0] nopI, ldR2, addA, addB, addC, addD, jal, errI;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .instr_IFID(instr_IFID), .PC2_IFID(PC2_IFID), .halt_IFID(halt_IFID),
        .takeBranch_EXMEM(takeBranch_EXMEM), .freeze(freeze),
        .wb_wrEn(wb_wrEn), .wb_wrReg(wb_wrReg), .wb_wrData(wb_wrData),
        .stallCtrl(stallCtrl), .instr_IDEX(instr_IDEX), .PC2_IDEX(PC2_IDEX),
        .rsData_IDEX(rsData_IDEX), .rtData_IDEX(rtData_IDEX), .wrReg_IDEX(wrReg_IDEX),
        .wrEn_IDEX(wrEn_IDEX), .memRead_IDEX(memRead_IDEX), .memWrite_IDEX(memWrite_IDEX),
        .halt_IDEX(halt_IDEX), .err_IDEX(err_IDEX), .stallCnt(stallCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mkInstr(input logic [4:0] op, input logic [2:0] rs,
                                            input logic [2:0] rt, input logic [2:0] rd);
        return {op, rs, rt, rd, 2'b00};
    endfunction

    function automatic logic [15:0] ctrl(input logic [2:0] w, input logic e, input logic mr,
                                         input logic mw, input logic h, input logic er);
        return {8'd0, w, e, mr, mw, h, er};
    endfunction

    function automatic logic [15:0] ctrlObs();
        return {8'd0, wrReg_IDEX, wrEn_IDEX, memRead_IDEX, memWrite_IDEX, halt_IDEX, err_IDEX};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc2,
                                 input logic halt, input logic branch);
        instr_IFID       = instr;
        PC2_IFID         = pc2;
        halt_IFID        = halt;
        takeBranch_EXMEM = branch;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nopI = 16'h0800;
        ldR2 = mkInstr(5'b10001, 3'd1, 3'd2, 3'd0);
        addA = mkInstr(5'b11011, 3'd3, 3'd4, 3'd5);
        addB = mkInstr(5'b11011, 3'd1, 3'd3, 3'd6);
        addC = mkInstr(5'b11011, 3'd2, 3'd4, 3'd1);
        addD = mkInstr(5'b11011, 3'd5, 3'd2, 3'd1);
        jal  = mkInstr(5'b00110, 3'd0, 3'd0, 3'd0);
        errI = mkInstr(5'b00010, 3'd0, 3'd0, 3'd0);

        rst = 1'b0;
        freeze = 1'b1;
        wb_wrEn = 1'b0;
        wb_wrReg = 3'd0;
        wb_wrData = 16'h0000;
        applyStimulus(nopI, 16'h0000, 1'b0, 1'b0);

        // Asynchronous reset, observed before any clock edge.
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_instr", instr_IDEX, 16'h0800);
        checkOutput("rst_pc2", PC2_IDEX, 16'h0000);
        checkOutput("rst_rs", rsData_IDEX, 16'h0000);
        checkOutput("rst_rt", rtData_IDEX, 16'h0000);
        checkOutput("rst_ctrl", ctrlObs(), 16'h0000);
        checkOutput("rst_stall", {15'd0, stallCtrl}, 16'h0000);
        checkOutput("rst_cnt", stallCnt, 16'h0000);
        stepClock();
        rst = 1'b0;

        // Same-cycle writeback bypass on Rs.
        wb_wrEn = 1'b1; wb_wrReg = 3'd3; wb_wrData = 16'hBEEF;
        applyStimulus(addA, 16'h0102, 1'b0, 1'b0);
        stepClock();
        checkOutput("byp_instr", instr_IDEX, addA);
        checkOutput("byp_pc2", PC2_IDEX, 16'h0102);
        checkOutput("byp_rs", rsData_IDEX, 16'hBEEF);
        checkOutput("byp_rt", rtData_IDEX, 16'h0000);
        checkOutput("byp_ctrl", ctrlObs(), ctrl(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Stored value read back from the file; r2 written this cycle.
        wb_wrReg = 3'd2; wb_wrData = 16'h1234;
        applyStimulus(addB, 16'h0104, 1'b0, 1'b0);
        stepClock();
        wb_wrEn = 1'b0;
        checkOutput("rf_rs", rsData_IDEX, 16'h0000);
        checkOutput("rf_rt", rtData_IDEX, 16'hBEEF);
        checkOutput("rf_ctrl", ctrlObs(), ctrl(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Load-use on Rs: one bubble, then the consumer enters.
        applyStimulus(ldR2, 16'h0106, 1'b0, 1'b0);
        stepClock();
        checkOutput("ld_ctrl", ctrlObs(), ctrl(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(addC, 16'h0108, 1'b0, 1'b0);
        #1;
        checkOutput("lu_stall", {15'd0, stallCtrl}, 16'h0001);
        stepClock();
        checkOutput("lu_bub_instr", instr_IDEX, 16'h0800);
        checkOutput("lu_bub_ctrl", ctrlObs(), 16'h0000);
        checkOutput("lu_bub_pc2", PC2_IDEX, 16'h0000);
        checkOutput("lu_cnt", stallCnt, 16'h0001);
        checkOutput("lu_stall_clr", {15'd0, stallCtrl}, 16'h0000);
        stepClock();
        checkOutput("lu_add_instr", instr_IDEX, addC);
        checkOutput("lu_add_rs", rsData_IDEX, 16'h1234);
        checkOutput("lu_add_ctrl", ctrlObs(), ctrl(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Taken branch overrides the stall.
        applyStimulus(ldR2, 16'h010A, 1'b0, 1'b0);
        stepClock();
        applyStimulus(addC, 16'h010C, 1'b0, 1'b1);
        #1;
        checkOutput("fl_stall", {15'd0, stallCtrl}, 16'h0000);
        stepClock();
        checkOutput("fl_instr", instr_IDEX, 16'h0800);
        checkOutput("fl_ctrl", ctrlObs(), 16'h0000);
        checkOutput("fl_cnt", stallCnt, 16'h0001);

        // Freeze during a load-use stall on Rt.
        applyStimulus(ldR2, 16'h010E, 1'b0, 1'b0);
        stepClock();
        applyStimulus(addD, 16'h0110, 1'b0, 1'b0);
        #1;
        checkOutput("fz_stall0", {15'd0, stallCtrl}, 16'h0001);
        freeze = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("fz_instr", instr_IDEX, ldR2);
            checkOutput("fz_stall", {15'd0, stallCtrl}, 16'h0001);
            checkOutput("fz_cnt", stallCnt, 16'h0001);
        end
        freeze = 1'b1;
        stepClock();
        checkOutput("fz_bub", instr_IDEX, 16'h0800);
        checkOutput("fz_cnt2", stallCnt, 16'h0002);
        stepClock();
        checkOutput("fz_add", instr_IDEX, addD);
        checkOutput("fz_add_rt", rtData_IDEX, 16'h1234);

        // Counter saturation from a preloaded maximum.
        applyStimulus(nopI, 16'h0000, 1'b0, 1'b0);
        force dut.stallCnt_q = 16'hFFFF;
        stepClock();
        stepClock();
        release dut.stallCnt_q;
        checkOutput("sat_pre", stallCnt, 16'hFFFF);
        applyStimulus(ldR2, 16'h0112, 1'b0, 1'b0);
        stepClock();
        applyStimulus(addC, 16'h0114, 1'b0, 1'b0);
        #1;
        checkOutput("sat_stall", {15'd0, stallCtrl}, 16'h0001);
        stepClock();
        checkOutput("sat_cnt", stallCnt, 16'hFFFF);
        checkOutput("sat_bub", instr_IDEX, 16'h0800);

        // Destination and flag decode across opcode classes.
        applyStimulus(jal, 16'h0200, 1'b1, 1'b0);
        stepClock();
        checkOutput("jal_ctrl", ctrlObs(), ctrl(3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        applyStimulus(errI, 16'h0202, 1'b0, 1'b0);
        stepClock();
        checkOutput("err_ctrl", ctrlObs(), ctrl(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        applyStimulus(mkInstr(5'b10000, 3'd1, 3'd2, 3'd0), 16'h0204, 1'b0, 1'b0);
        stepClock();
        checkOutput("st_ctrl", ctrlObs(), ctrl(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        checkOutput("st_rt", rtData_IDEX, 16'h1234);
        applyStimulus(mkInstr(5'b10011, 3'd4, 3'd2, 3'd0), 16'h0206, 1'b0, 1'b0);
        stepClock();
        checkOutput("stu_ctrl", ctrlObs(), ctrl(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        applyStimulus(mkInstr(5'b11000, 3'd6, 3'd0, 3'd0), 16'h0208, 1'b0, 1'b0);
        stepClock();
        checkOutput("lbi_ctrl", ctrlObs(), ctrl(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus(mkInstr(5'b01001, 3'd0, 3'd3, 3'd0), 16'h020A, 1'b0, 1'b0);
        stepClock();
        checkOutput("imm_ctrl", ctrlObs(), ctrl(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // A load followed by an instruction that ignores Rs does not stall.
        applyStimulus(ldR2, 16'h020C, 1'b0, 1'b0);
        stepClock();
        applyStimulus(mkInstr(5'b00110, 3'd2, 3'd0, 3'd0), 16'h020E, 1'b0, 1'b0);
        #1;
        checkOutput("nouse_stall", {15'd0, stallCtrl}, 16'h0000);
        stepClock();
        checkOutput("nouse_instr", instr_IDEX, mkInstr(5'b00110, 3'd2, 3'd0, 3'd0));

        // Reset asserted mid-stall.
        applyStimulus(ldR2, 16'h0210, 1'b0, 1'b0);
        stepClock();
        applyStimulus(addC, 16'h0212, 1'b0, 1'b0);
        #1;
        checkOutput("mr_stall", {15'd0, stallCtrl}, 16'h0001);
        rst = 1'b1;
        #1;
        checkOutput("mr_stall_clr", {15'd0, stallCtrl}, 16'h0000);
        checkOutput("mr_instr", instr_IDEX, 16'h0800);
        checkOutput("mr_cnt", stallCnt, 16'h0000);
        stepClock();
        rst = 1'b0;
        applyStimulus(mkInstr(5'b11011, 3'd3, 3'd2, 3'd1), 16'h0214, 1'b0, 1'b0);
        stepClock();
        checkOutput("mr_rf_rs", rsData_IDEX, 16'h0000);
        checkOutput("mr_rf_rt", rtData_IDEX, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
